// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, issues one outstanding imem request at a time,
// and buffers a single fetched instruction for decode.
module ysyx_22040088_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_fault,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic [63:0] r_req_addr, w_req_addr_nxt;
    logic [63:0] r_buf_pc, w_buf_pc_nxt;
    logic [31:0] r_buf_inst, w_buf_inst_nxt;
    logic        r_buf_fault, w_buf_fault_nxt;
    logic        r_kill, w_kill_nxt;
    logic        r_req_valid, r_if_valid;
    logic [63:0] w_redir_pc;
    logic        w_unused;

    assign w_redir_pc = {redirect_pc[63:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];

    // r_req_addr is the address on the bus; r_pc may move ahead of it on a redirect
    // while the old request is still pending.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_req_addr_nxt  = r_req_addr;
        w_buf_pc_nxt    = r_buf_pc;
        w_buf_inst_nxt  = r_buf_inst;
        w_buf_fault_nxt = r_buf_fault;
        w_kill_nxt      = r_kill;
        case (r_state)
            S_BOOT: begin
                w_state_nxt    = S_REQ;
                w_req_addr_nxt = r_pc;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt   = w_redir_pc;
                    w_kill_nxt = 1'b1;
                end
                if (imem_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_kill_nxt = 1'b0;
                    if (r_kill || redirect_valid) begin
                        w_state_nxt    = S_REQ;
                        w_pc_nxt       = redirect_valid ? w_redir_pc : r_pc;
                        w_req_addr_nxt = w_pc_nxt;
                    end else begin
                        w_state_nxt     = S_HOLD;
                        w_buf_pc_nxt    = r_req_addr;
                        w_buf_inst_nxt  = imem_resp_err ? NOP_INST : imem_resp_data;
                        w_buf_fault_nxt = imem_resp_err;
                    end
                end else if (redirect_valid) begin
                    w_pc_nxt   = w_redir_pc;
                    w_kill_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (if_ready && (halt || r_buf_fault)) begin
                    w_state_nxt = S_HALTED;
                    w_kill_nxt  = 1'b0;
                end else if (redirect_valid) begin
                    w_state_nxt    = S_REQ;
                    w_pc_nxt       = w_redir_pc;
                    w_req_addr_nxt = w_redir_pc;
                end else if (if_ready) begin
                    w_state_nxt    = S_REQ;
                    w_pc_nxt       = r_buf_pc + 64'd4;
                    w_req_addr_nxt = w_pc_nxt;
                end
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_buf_pc    <= '0;
            r_buf_inst  <= '0;
            r_buf_fault <= 1'b0;
            r_kill      <= 1'b0;
            r_req_valid <= 1'b0;
            r_if_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_buf_inst  <= w_buf_inst_nxt;
            r_buf_fault <= w_buf_fault_nxt;
            r_kill      <= w_kill_nxt;
            r_req_valid <= (w_state_nxt == S_REQ);
            r_if_valid  <= (w_state_nxt == S_HOLD);
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_buf_pc;
    assign if_inst        = r_buf_inst;
    assign if_fault       = r_buf_fault;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Directed bench for the fetch unit; expected instructions go through a scoreboard queue.
module tb_ysyx_22040088_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt = 1'b0;

    ysyx_22040088_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .imem_resp_err(imem_resp_err),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_inst(if_inst), .if_fault(if_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_tot  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic req_accept(input logic [63:0] addr);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("req_valid", imem_req_valid, 1);
        chk("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_no_req", imem_req_valid, 0);
    endtask

    // keep=1 means the bench expects this response to reach decode
    task automatic respond(input logic [63:0] pc, input logic [31:0] data,
                           input logic err, input logic keep);
        if (keep) exp_q.push_back('{pc, err ? 32'h0000_0013 : data, err});
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        imem_resp_err   = err;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
    endtask

    task automatic check_if();
        exp_t e;
        int   n = 0;
        while (if_valid !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        chk("if_valid", if_valid, 1);
        if (exp_q.size() == 0) begin
            n_tot++;
            n_fail++;
            $error("FAIL sb_empty: got instruction %h with no expectation", if_inst);
        end else begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_inst", {32'h0, if_inst}, {32'h0, e.inst});
            chk("if_fault", if_fault, e.fault);
        end
    endtask

    task automatic handshake(input logic h);
        if_ready = 1'b1;
        halt     = h;
        tick();
        if_ready = 1'b0;
        halt     = 1'b0;
    endtask

    task automatic chk_halted(input string tag);
        repeat (4) begin
            tick();
            chk({tag, "_req"}, imem_req_valid, 0);
            chk({tag, "_ifv"}, if_valid, 0);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_req_addr"}, imem_req_addr, 64'h8000_0000);
        chk({tag, "_if_valid"}, if_valid, 0);
        chk({tag, "_if_pc"}, if_pc, 0);
        chk({tag, "_if_inst"}, {32'h0, if_inst}, 0);
        chk({tag, "_if_fault"}, if_fault, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_outs("rst");
        rst = 1'b1;
        chk("boot_no_req", imem_req_valid, 0);
        tick();

        // two back-to-back fetches, first one stalled by decode for 3 cycles
        req_accept(64'h8000_0000);
        respond(64'h8000_0000, 32'h0010_0093, 1'b0, 1'b1);
        check_if();
        repeat (3) begin
            tick();
            chk("stall_ifv", if_valid, 1);
            chk("stall_pc", if_pc, 64'h8000_0000);
            chk("stall_inst", {32'h0, if_inst}, 64'h0010_0093);
            chk("stall_req", imem_req_valid, 0);
        end
        handshake(1'b0);
        chk("post_hs_ifv", if_valid, 0);
        req_accept(64'h8000_0004);
        respond(64'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
        check_if();
        handshake(1'b0);

        // redirect coinciding with handshake in HOLD
        req_accept(64'h8000_0008);
        respond(64'h8000_0008, 32'h0030_0193, 1'b0, 1'b1);
        check_if();
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_hold_ifv", if_valid, 0);
        chk("redir_hold_addr", imem_req_addr, 64'h8000_0200);

        // redirect while in WAIT squashes the in-flight response
        req_accept(64'h8000_0200);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        respond(64'h0, 32'hdead_beef, 1'b0, 1'b0);
        chk("kill_ifv", if_valid, 0);
        tick();
        chk("kill_ifv2", if_valid, 0);
        req_accept(64'h8000_0100);

        // faulted fetch halts after handshake
        respond(64'h8000_0100, 32'h0040_0213, 1'b1, 1'b1);
        check_if();
        handshake(1'b0);
        chk_halted("fault_halt");

        // halt from decode
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        req_accept(64'h8000_0000);
        respond(64'h8000_0000, 32'h0010_0073, 1'b0, 1'b1);
        check_if();
        handshake(1'b1);
        chk_halted("ebreak_halt");

        // reset in WAIT, stale response arrives during BOOT
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        req_accept(64'h8000_0000);
        rst = 1'b0;
        #1;
        chk_reset_outs("async");
        tick();
        rst             = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        chk("stale_ifv", if_valid, 0);
        chk("stale_req", imem_req_valid, 1);
        tick();
        chk("stale_ifv2", if_valid, 0);
        req_accept(64'h8000_0000);
        respond(64'h8000_0000, 32'h0050_0293, 1'b0, 1'b1);
        check_if();
        handshake(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
